// File: rtl/time_of_day_counter.sv
// Time-of-day counter: hh:mm:ss fields with 1 s prescaler, carry-chained rollover,
// per-field up/down adjust (no carry), synchronous load and a 12/24 h display view.
// Latency: fields and pulses update 1 clock after the terminal prescaler count.
// Backpressure: none; i_Run=0 freezes the prescaler and time, and load/adjust still apply.
//
// Ports:
//   i_Clk, i_Reset_n           clock; asynchronous active-low reset
//   i_Run                      enable for the prescaler and time keeping
//   i_Load, i_Load_*           one-cycle load strobe and the 24 h values to load
//   i_Hour_Adj, i_Min_Adj      per-cycle single-step adjust of hours and minutes
//   i_Adj_Down                 adjust direction (0 = +1, 1 = -1)
//   i_Mode_12h                 display mode for o_Hours (1 = 12 h)
//   o_Hours/o_Minutes/o_Seconds displayed time; o_PM set when internal hours >= 12
//   o_Sec_Tick, o_Day_Wrap     registered one-cycle pulses on tick and midnight rollover
module time_of_day_counter #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int START_HOURS   = 0,
  parameter int START_MINUTES = 0,
  parameter int START_SECONDS = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Run,
  input  logic       i_Load,
  input  logic [4:0] i_Load_Hours,
  input  logic [5:0] i_Load_Minutes,
  input  logic [5:0] i_Load_Seconds,
  input  logic       i_Hour_Adj,
  input  logic       i_Min_Adj,
  input  logic       i_Adj_Down,
  input  logic       i_Mode_12h,
  output logic [4:0] o_Hours,
  output logic [5:0] o_Minutes,
  output logic [5:0] o_Seconds,
  output logic       o_PM,
  output logic       o_Sec_Tick,
  output logic       o_Day_Wrap
);

  // A divider of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4:0]      START_H   = 5'(START_HOURS);
  localparam logic [5:0]      START_M   = 6'(START_MINUTES);
  localparam logic [5:0]      START_S   = 6'(START_SECONDS);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;

  logic          tick_w;
  logic          adj_w;
  logic          sec_last_w;
  logic          min_last_w;
  logic          hour_last_w;

  // Wrap-within-field step used by adjust; never produces a carry.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic down);
    if (down) return (v == 6'd0)  ? 6'd59 : v - 6'd1;
    else      return (v >= 6'd59) ? 6'd0  : v + 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic down);
    if (down) return (v == 5'd0)  ? 5'd23 : v - 5'd1;
    else      return (v >= 5'd23) ? 5'd0  : v + 5'd1;
  endfunction

  assign tick_w      = i_Run && (presc_q == PRESC_MAX);
  assign adj_w       = i_Hour_Adj || i_Min_Adj;
  assign sec_last_w  = (seconds_q == 6'd59);
  assign min_last_w  = (minutes_q == 6'd59);
  assign hour_last_w = (hours_q   == 5'd23);

  // Priority load > adjust > tick. A tick losing to load/adjust is dropped,
  // and both of those restart the prescaler, so the next second is a full one.
  always_comb begin
    presc_d    = presc_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;

    if (i_Load) begin
      hours_d   = (i_Load_Hours   > 5'd23) ? 5'd0 : i_Load_Hours;
      minutes_d = (i_Load_Minutes > 6'd59) ? 6'd0 : i_Load_Minutes;
      seconds_d = (i_Load_Seconds > 6'd59) ? 6'd0 : i_Load_Seconds;
      presc_d   = '0;
    end else if (adj_w) begin
      if (i_Hour_Adj) hours_d   = step24(hours_q, i_Adj_Down);
      if (i_Min_Adj)  minutes_d = step60(minutes_q, i_Adj_Down);
      seconds_d = 6'd0;
      presc_d   = '0;
    end else if (tick_w) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_last_w) begin
        seconds_d = 6'd0;
        if (min_last_w) begin
          minutes_d = 6'd0;
          if (hour_last_w) begin
            hours_d    = 5'd0;
            day_wrap_d = 1'b1;
          end else begin
            hours_d = hours_q + 5'd1;
          end
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end else if (i_Run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      presc_q    <= '0;
      hours_q    <= START_H;
      minutes_q  <= START_M;
      seconds_q  <= START_S;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  // Display view is purely combinational so a mode change shows immediately.
  always_comb begin
    o_Hours = hours_q;
    if (i_Mode_12h) begin
      if (hours_q == 5'd0)      o_Hours = 5'd12;
      else if (hours_q > 5'd12) o_Hours = hours_q - 5'd12;
    end
  end

  assign o_Minutes  = minutes_q;
  assign o_Seconds  = seconds_q;
  assign o_PM       = (hours_q >= 5'd12);
  assign o_Sec_Tick = sec_tick_q;
  assign o_Day_Wrap = day_wrap_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICK_DIV=4 and start time 23:59:58.
module tb_time_of_day_counter;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       load;
  logic [4:0] ld_h;
  logic [5:0] ld_m;
  logic [5:0] ld_s;
  logic       hour_adj;
  logic       min_adj;
  logic       adj_down;
  logic       mode12;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       pm;
  logic       sec_tick;
  logic       day_wrap;

  int n_cmp = 0;
  int n_err = 0;
  logic tick_seen;

  time_of_day_counter #(
    .TICK_DIV(4), .START_HOURS(23), .START_MINUTES(59), .START_SECONDS(58)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Run(run), .i_Load(load),
    .i_Load_Hours(ld_h), .i_Load_Minutes(ld_m), .i_Load_Seconds(ld_s),
    .i_Hour_Adj(hour_adj), .i_Min_Adj(min_adj), .i_Adj_Down(adj_down),
    .i_Mode_12h(mode12), .o_Hours(hours), .o_Minutes(minutes), .o_Seconds(seconds),
    .o_PM(pm), .o_Sec_Tick(sec_tick), .o_Day_Wrap(day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".h"}, 32'(hours), 32'(h));
    check({tag, ".m"}, 32'(minutes), 32'(m));
    check({tag, ".s"}, 32'(seconds), 32'(s));
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    ld_h = 5'(h); ld_m = 6'(m); ld_s = 6'(s);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; load = 1'b0; ld_h = '0; ld_m = '0; ld_s = '0;
    hour_adj = 1'b0; min_adj = 1'b0; adj_down = 1'b0; mode12 = 1'b0;

    // Reset state
    step(); step();
    check_time("reset", 23, 59, 58);
    check("reset.pm", 32'(pm), 1);
    check("reset.tick", 32'(sec_tick), 0);
    check("reset.wrap", 32'(day_wrap), 0);

    // 1. Ticks every 4th cycle, midnight rollover
    rst_n = 1'b1;
    run   = 1'b1;
    tick_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); tick_seen |= sec_tick; end
    check("t1.early_tick", 32'(tick_seen), 0);
    step();
    check("t1.tick1", 32'(sec_tick), 1);
    check_time("t1.t1", 23, 59, 59);
    check("t1.wrap_t1", 32'(day_wrap), 0);
    step();
    check("t1.tick_drop", 32'(sec_tick), 0);
    step(); step(); step();
    check("t1.tick2", 32'(sec_tick), 1);
    check("t1.wrap", 32'(day_wrap), 1);
    check_time("t1.t2", 0, 0, 0);
    check("t1.pm0", 32'(pm), 0);
    step();
    check("t1.wrap_drop", 32'(day_wrap), 0);

    // 2. 12/24 h display
    run = 1'b0;
    mode12 = 1'b1;
    do_load(0, 15, 0);
    check("t2.h00_12", 32'(hours), 12);
    check("t2.pm00", 32'(pm), 0);
    do_load(12, 0, 0);
    check("t2.h12_12", 32'(hours), 12);
    check("t2.pm12", 32'(pm), 1);
    do_load(13, 5, 0);
    check("t2.h13_12", 32'(hours), 1);
    check("t2.pm13", 32'(pm), 1);
    mode12 = 1'b0;
    #1;
    check("t2.h13_24", 32'(hours), 13);
    do_load(0, 15, 0);
    check("t2.h00_24", 32'(hours), 0);
    do_load(12, 0, 0);
    check("t2.h12_24", 32'(hours), 12);

    // 3. Adjust wraps within the field, clears seconds
    do_load(10, 59, 30);
    min_adj = 1'b1; step(); min_adj = 1'b0;
    check_time("t3.min_up", 10, 0, 0);
    check("t3.min_up_tick", 32'(sec_tick), 0);
    do_load(0, 20, 10);
    hour_adj = 1'b1; adj_down = 1'b1; step(); hour_adj = 1'b0; adj_down = 1'b0;
    check_time("t3.hr_dn", 23, 20, 0);
    do_load(23, 59, 10);
    hour_adj = 1'b1; min_adj = 1'b1; step(); hour_adj = 1'b0; min_adj = 1'b0;
    check_time("t3.both_up", 0, 0, 0);
    check("t3.both_wrap", 32'(day_wrap), 0);

    // 4. Out-of-range load, full second to the next tick
    run = 1'b1;
    do_load(25, 61, 7);
    check_time("t4.load", 0, 0, 7);
    check("t4.tick", 32'(sec_tick), 0);
    check("t4.wrap", 32'(day_wrap), 0);
    tick_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); tick_seen |= sec_tick; end
    check("t4.early_tick", 32'(tick_seen), 0);
    step();
    check("t4.tick_at4", 32'(sec_tick), 1);
    check_time("t4.after", 0, 0, 8);

    // 5. Tick, adjust and load coincide: load wins
    step(); step(); step();
    min_adj = 1'b1;
    do_load(5, 6, 7);
    min_adj = 1'b0;
    check_time("t5.load", 5, 6, 7);
    check("t5.tick", 32'(sec_tick), 0);
    tick_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); tick_seen |= sec_tick; end
    check("t5.early_tick", 32'(tick_seen), 0);
    step();
    check("t5.tick_at4", 32'(sec_tick), 1);
    check_time("t5.after", 5, 6, 8);

    // 6. Asynchronous reset while the tick pulse is high
    step(); step(); step(); step();
    check("t6.pre_tick", 32'(sec_tick), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_time("t6.async", 23, 59, 58);
    check("t6.async_tick", 32'(sec_tick), 0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    tick_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); tick_seen |= sec_tick; end
    check("t6.frozen_tick", 32'(tick_seen), 0);
    check_time("t6.frozen", 23, 59, 58);
    run = 1'b1;
    tick_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); tick_seen |= sec_tick; end
    check("t6.early_tick", 32'(tick_seen), 0);
    step();
    check("t6.first_tick", 32'(sec_tick), 1);
    check_time("t6.first", 23, 59, 59);

    // Prescaler holds mid-count while i_Run=0
    step(); step();
    run = 1'b0;
    tick_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); tick_seen |= sec_tick; end
    check("t6.hold_tick", 32'(tick_seen), 0);
    check_time("t6.hold", 23, 59, 59);
    run = 1'b1;
    step();
    check("t6.resume1", 32'(sec_tick), 0);
    step();
    check("t6.resume2", 32'(sec_tick), 1);
    check("t6.resume_wrap", 32'(day_wrap), 1);
    check_time("t6.resume", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
